// File: rtl/stump_control.sv
// Stump processor control unit: instruction register, FETCH/EXECUTE/MEMORY
// sequencer, ALU/register-bank/memory control decode, condition-code register
// and branch-condition evaluation. All control outputs are decoded from the
// current state and the latched instruction only.
module stump_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [3:0]  flags_in,
    output logic [1:0]  state,
    output logic [15:0] ir,
    output logic [3:0]  cc,
    output logic [2:0]  func,
    output logic        c_in,
    output logic [2:0]  srcA,
    output logic [2:0]  srcB,
    output logic [2:0]  dest,
    output logic [1:0]  shift_op,
    output logic        imm_sel,
    output logic [15:0] imm16,
    output logic        reg_write,
    output logic        data_sel,
    output logic        addr_sel,
    output logic        addr_en,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic        pc_inc,
    output logic        cond_met
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXECUTE = 2'b01,
        S_MEMORY  = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADC  = 3'b001,
        OP_SUB  = 3'b010,
        OP_SBC  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_LDST = 3'b110,
        OP_BCC  = 3'b111
    } op_t;

    localparam logic [2:0] PC_REG   = 3'd7;
    localparam logic [2:0] FUNC_ADD = 3'b000;

    state_t state_q;
    state_t state_d;

    // Instruction fields, all taken from the latched instruction.
    op_t         op;
    logic        is_imm;
    logic        s_bit;      // S for ALU ops, L/S (1 = store) for LD/ST
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [1:0]  shift_fld;
    logic [4:0]  imm5;
    logic [3:0]  cond;
    logic [7:0]  offset;
    logic        is_alu;
    logic [15:0] imm5_ext;
    logic [15:0] offset_ext;
    logic        cc_write;

    assign op         = op_t'(ir[15:13]);
    assign is_imm     = ir[12];
    assign s_bit      = ir[11];
    assign rd         = ir[10:8];
    assign ra         = ir[7:5];
    assign rb         = ir[4:2];
    assign shift_fld  = ir[1:0];
    assign imm5       = ir[4:0];
    assign cond       = ir[11:8];
    assign offset     = ir[7:0];
    assign is_alu     = (ir[15:14] != 2'b11);
    assign imm5_ext   = {{11{imm5[4]}}, imm5};
    assign offset_ext = {{8{offset[7]}}, offset};

    // Flags are only captured at the end of EXECUTE of an ALU op with S set;
    // an asynchronous reset during EXECUTE wins and discards the update.
    assign cc_write   = (state_q == S_EXECUTE) && is_alu && s_bit;

    assign state = state_q;
    // Carry-in is the register value, so ADC/SBC see the carry from before
    // the instruction that is currently executing.
    assign c_in  = cc[0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register: loaded from memory read data during FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= 16'h0000;
        end else if (state_q == S_FETCH) begin
            ir <= instr;
        end
    end

    // Condition-code register: captures ALU flags {N,Z,V,C}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc <= 4'b0000;
        end else if (cc_write) begin
            cc <= flags_in;
        end
    end

    // Branch condition evaluation from cc and the condition field.
    always_comb begin
        logic n_f;
        logic z_f;
        logic v_f;
        logic c_f;
        n_f = cc[3];
        z_f = cc[2];
        v_f = cc[1];
        c_f = cc[0];
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        cond_met = 1'b0;
        case (cond)
            4'h0: cond_met = 1'b1;                      // AL
            4'h1: cond_met = 1'b0;                      // NV
            4'h2: cond_met = !c_f && !z_f;              // HI
            4'h3: cond_met = c_f || z_f;                // LS
            4'h4: cond_met = !c_f;                      // CC
            4'h5: cond_met = c_f;                       // CS
            4'h6: cond_met = !z_f;                      // NE
            4'h7: cond_met = z_f;                       // EQ
            4'h8: cond_met = !v_f;                      // VC
            4'h9: cond_met = v_f;                       // VS
            4'hA: cond_met = !n_f;                      // PL
            4'hB: cond_met = n_f;                       // MI
            4'hC: cond_met = (n_f == v_f);              // GE
            4'hD: cond_met = (n_f != v_f);              // LT
            4'hE: cond_met = !z_f && (n_f == v_f);      // GT
            4'hF: cond_met = z_f || (n_f != v_f);       // LE
            default: cond_met = 1'b0;
        endcase
    end

    // Next-state logic: only LD/ST visits MEMORY; the unused encoding recovers.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_EXECUTE;
            S_EXECUTE: state_d = (op == OP_LDST) ? S_MEMORY : S_FETCH;
            S_MEMORY:  state_d = S_FETCH;
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Control decode: everything not asserted for the current state stays 0.
    always_comb begin
        func      = FUNC_ADD;
        srcA      = 3'd0;
        srcB      = 3'd0;
        dest      = 3'd0;
        shift_op  = 2'b00;
        imm_sel   = 1'b0;
        imm16     = 16'h0000;
        reg_write = 1'b0;
        data_sel  = 1'b0;
        addr_sel  = 1'b0;
        addr_en   = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        pc_inc    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // Read the instruction at PC and advance PC.
                mem_ren = 1'b1;
                pc_inc  = 1'b1;
            end

            S_EXECUTE: begin
                if (op == OP_BCC) begin
                    // PC-relative branch: R7 <= R7 + offset when taken.
                    func      = FUNC_ADD;
                    srcA      = PC_REG;
                    dest      = PC_REG;
                    imm_sel   = 1'b1;
                    imm16     = offset_ext;
                    reg_write = cond_met;
                end else begin
                    // ALU ops use their own function; LD/ST adds base + offset.
                    func = is_alu ? ir[15:13] : FUNC_ADD;
                    srcA = ra;
                    srcB = rb;
                    dest = rd;
                    if (is_imm) begin
                        imm_sel = 1'b1;
                        imm16   = imm5_ext;
                    end else begin
                        shift_op = shift_fld;
                    end
                    if (is_alu) begin
                        reg_write = 1'b1;
                        data_sel  = 1'b0;
                    end else begin
                        addr_en = 1'b1;
                    end
                end
            end

            S_MEMORY: begin
                addr_sel = 1'b1;
                if (s_bit) begin
                    // Store: Rd supplies the write data on read port A.
                    mem_wen = 1'b1;
                    srcA    = rd;
                end else begin
                    // Load: memory data is written back into Rd.
                    mem_ren   = 1'b1;
                    reg_write = 1'b1;
                    data_sel  = 1'b1;
                    dest      = rd;
                end
            end

            S_ILLEGAL: begin
                // All strobes held low; the sequencer returns to FETCH.
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_stump_control.sv
// Self-checking bench for stump_control: a cycle-level behavioural model of
// the instruction sequence is compared against the DUT on every falling edge,
// and directed vectors carry hand-computed literal expectations.
module tb_stump_control;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic [3:0]  flags_in;
    logic [1:0]  state;
    logic [15:0] ir;
    logic [3:0]  cc;
    logic [2:0]  func;
    logic        c_in;
    logic [2:0]  srcA;
    logic [2:0]  srcB;
    logic [2:0]  dest;
    logic [1:0]  shift_op;
    logic        imm_sel;
    logic [15:0] imm16;
    logic        reg_write;
    logic        data_sel;
    logic        addr_sel;
    logic        addr_en;
    logic        mem_ren;
    logic        mem_wen;
    logic        pc_inc;
    logic        cond_met;

    stump_control dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .flags_in  (flags_in),
        .state     (state),
        .ir        (ir),
        .cc        (cc),
        .func      (func),
        .c_in      (c_in),
        .srcA      (srcA),
        .srcB      (srcB),
        .dest      (dest),
        .shift_op  (shift_op),
        .imm_sel   (imm_sel),
        .imm16     (imm16),
        .reg_write (reg_write),
        .data_sel  (data_sel),
        .addr_sel  (addr_sel),
        .addr_en   (addr_en),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .pc_inc    (pc_inc),
        .cond_met  (cond_met)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: step within the current instruction (0 = fetch),
    // the instruction being executed and the condition codes.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [1:0]  state;
        logic [15:0] ir;
        logic [3:0]  cc;
        logic [2:0]  func;
        logic        c_in;
        logic [2:0]  src_a;
        logic [2:0]  src_b;
        logic [2:0]  dest;
        logic [1:0]  shift_op;
        logic        imm_sel;
        logic [15:0] imm16;
        logic        reg_write;
        logic        data_sel;
        logic        addr_sel;
        logic        addr_en;
        logic        mem_ren;
        logic        mem_wen;
        logic        pc_inc;
        logic        cond_met;
    } outs_t;

    int          m_step = 0;
    logic [15:0] m_ir   = 16'h0000;
    logic [3:0]  m_cc   = 4'b0000;
    outs_t       exp_o;

    // Odd condition codes are the negation of the even code below them.
    function automatic logic cond_true(input logic [3:0] cd, input logic [3:0] c);
        logic n, z, v, cy, base;
        n = c[3]; z = c[2]; v = c[1]; cy = c[0];
        case (cd[3:1])
            3'd0: base = 1'b1;
            3'd1: base = !cy && !z;
            3'd2: base = !cy;
            3'd3: base = !z;
            3'd4: base = !v;
            3'd5: base = !n;
            3'd6: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ cd[0];
    endfunction

    function automatic outs_t model_outputs(input int step, input logic [15:0] w, input logic [3:0] c);
        outs_t o;
        logic [2:0] op;
        o = '0;
        op = w[15:13];
        o.state    = step[1:0];
        o.ir       = w;
        o.cc       = c;
        o.c_in     = c[0];
        o.cond_met = cond_true(w[11:8], c);
        if (step == 0) begin
            o.mem_ren = 1'b1;
            o.pc_inc  = 1'b1;
        end else if (step == 1) begin
            if (op == 3'd7) begin
                o.src_a     = 3'd7;
                o.dest      = 3'd7;
                o.imm_sel   = 1'b1;
                o.imm16     = 16'(signed'(w[7:0]));
                o.reg_write = o.cond_met;
            end else begin
                o.func  = (op < 3'd6) ? op : 3'd0;
                o.src_a = w[7:5];
                o.src_b = w[4:2];
                o.dest  = w[10:8];
                if (w[12]) begin
                    o.imm_sel = 1'b1;
                    o.imm16   = 16'(signed'(w[4:0]));
                end else begin
                    o.shift_op = w[1:0];
                end
                if (op < 3'd6) o.reg_write = 1'b1;
                else           o.addr_en   = 1'b1;
            end
        end else begin
            o.addr_sel = 1'b1;
            if (w[11]) begin
                o.mem_wen = 1'b1;
                o.src_a   = w[10:8];
            end else begin
                o.mem_ren   = 1'b1;
                o.reg_write = 1'b1;
                o.data_sel  = 1'b1;
                o.dest      = w[10:8];
            end
        end
        return o;
    endfunction

    // Model advance: instructions last 2 steps, LD/ST 3 steps.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_step = 0;
            m_ir   = 16'h0000;
            m_cc   = 4'b0000;
        end else if (m_step == 0) begin
            m_ir   = instr;
            m_step = 1;
        end else if (m_step == 1) begin
            if (m_ir[15:13] < 3'd6 && m_ir[11]) m_cc = flags_in;
            m_step = (m_ir[15:13] == 3'd6) ? 2 : 0;
        end else begin
            m_step = 0;
        end
    end

    // Compare process: every output checked against the model each cycle.
    always @(negedge clk) begin
        exp_o = model_outputs(m_step, m_ir, m_cc);
        check("state",     16'(state),     16'(exp_o.state));
        check("ir",        ir,             exp_o.ir);
        check("cc",        16'(cc),        16'(exp_o.cc));
        check("func",      16'(func),      16'(exp_o.func));
        check("c_in",      16'(c_in),      16'(exp_o.c_in));
        check("srcA",      16'(srcA),      16'(exp_o.src_a));
        check("srcB",      16'(srcB),      16'(exp_o.src_b));
        check("dest",      16'(dest),      16'(exp_o.dest));
        check("shift_op",  16'(shift_op),  16'(exp_o.shift_op));
        check("imm_sel",   16'(imm_sel),   16'(exp_o.imm_sel));
        check("imm16",     imm16,          exp_o.imm16);
        check("reg_write", 16'(reg_write), 16'(exp_o.reg_write));
        check("data_sel",  16'(data_sel),  16'(exp_o.data_sel));
        check("addr_sel",  16'(addr_sel),  16'(exp_o.addr_sel));
        check("addr_en",   16'(addr_en),   16'(exp_o.addr_en));
        check("mem_ren",   16'(mem_ren),   16'(exp_o.mem_ren));
        check("mem_wen",   16'(mem_wen),   16'(exp_o.mem_wen));
        check("pc_inc",    16'(pc_inc),    16'(exp_o.pc_inc));
        check("cond_met",  16'(cond_met),  16'(exp_o.cond_met));
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input logic [15:0] w, input logic [3:0] f);
        instr    = w;
        flags_in = f;
        repeat ((w[15:13] == 3'b110) ? 3 : 2) tick();
    endtask

    logic [15:0] tbl_instr [8];
    logic [3:0]  tbl_flags [8];

    initial begin
        rst      = 1'b1;
        instr    = 16'h0000;
        flags_in = 4'b0000;
        #2;
        check("reset state", 16'(state), 16'h0000);
        check("reset ir",    ir,         16'h0000);
        check("reset cc",    16'(cc),    16'h0000);
        #20 rst = 1'b0;

        // ADD R1, R2, R3 with S=1: flags captured at the end of EXECUTE.
        instr    = 16'h094C;
        flags_in = 4'b0101;
        tick();
        check("add func",      16'(func),      16'h0000);
        check("add srcA",      16'(srcA),      16'h0002);
        check("add srcB",      16'(srcB),      16'h0003);
        check("add dest",      16'(dest),      16'h0001);
        check("add reg_write", 16'(reg_write), 16'h0001);
        check("add cc before", 16'(cc),        16'h0000);
        tick();
        check("add cc after",  16'(cc),        16'h0005);
        check("add state",     16'(state),     16'h0000);

        // ADD without S leaves cc alone.
        run(16'h094C, 4'b1000);
        check("preset cc", 16'(cc), 16'h0008);
        instr    = 16'h014C;
        flags_in = 4'b0101;
        tick();
        check("add_ns reg_write", 16'(reg_write), 16'h0001);
        tick();
        check("add_ns cc", 16'(cc), 16'h0008);

        // LD R4, [R5, #-1]
        instr    = 16'hD4BF;
        flags_in = 4'b1111;
        tick();
        check("ld imm_sel",   16'(imm_sel),   16'h0001);
        check("ld imm16",     imm16,          16'hFFFF);
        check("ld addr_en",   16'(addr_en),   16'h0001);
        check("ld reg_write", 16'(reg_write), 16'h0000);
        tick();
        check("ld state",     16'(state),     16'h0002);
        check("ld mem_ren",   16'(mem_ren),   16'h0001);
        check("ld addr_sel",  16'(addr_sel),  16'h0001);
        check("ld reg_write", 16'(reg_write), 16'h0001);
        check("ld data_sel",  16'(data_sel),  16'h0001);
        check("ld dest",      16'(dest),      16'h0004);
        tick();
        check("ld back to fetch", 16'(state), 16'h0000);
        check("ld cc", 16'(cc), 16'h0008);

        // ST R4, [R5, #-1]
        instr = 16'hDCBF;
        tick();
        tick();
        check("st mem_wen",   16'(mem_wen),   16'h0001);
        check("st srcA",      16'(srcA),      16'h0004);
        check("st reg_write", 16'(reg_write), 16'h0000);
        tick();
        check("st cc", 16'(cc), 16'h0008);

        // BEQ -2, taken with Z set
        run(16'h094C, 4'b0100);
        instr = 16'hF7FE;
        tick();
        check("beq cond_met",  16'(cond_met),  16'h0001);
        check("beq reg_write", 16'(reg_write), 16'h0001);
        check("beq dest",      16'(dest),      16'h0007);
        check("beq imm16",     imm16,          16'hFFFE);
        tick();

        // BEQ not taken with Z clear
        run(16'h094C, 4'b0000);
        instr = 16'hF7FE;
        tick();
        check("beq_nt reg_write", 16'(reg_write), 16'h0000);
        check("beq_nt cond_met",  16'(cond_met),  16'h0000);
        tick();

        // Mixed sequence checked by the model only.
        tbl_instr[0] = 16'h2D4D; tbl_flags[0] = 4'b1001;  // ADC reg, shift 01, S
        tbl_instr[1] = 16'h7A3F; tbl_flags[1] = 4'b0110;  // SBC imm, no S
        tbl_instr[2] = 16'hFC10; tbl_flags[2] = 4'b0000;  // BGE (N=1,V=0)
        tbl_instr[3] = 16'h9E21; tbl_flags[3] = 4'b1010;  // AND imm, S
        tbl_instr[4] = 16'hFE80; tbl_flags[4] = 4'b0000;  // BGT (N==V, !Z)
        tbl_instr[5] = 16'hA9E2; tbl_flags[5] = 4'b0101;  // OR reg, shift 10, S
        tbl_instr[6] = 16'hF203; tbl_flags[6] = 4'b0000;  // BHI
        tbl_instr[7] = 16'hF105; tbl_flags[7] = 4'b0000;  // BNV
        for (int i = 0; i < 8; i++) run(tbl_instr[i], tbl_flags[i]);

        // Asynchronous reset in the middle of EXECUTE aborts the instruction.
        run(16'h094C, 4'b1010);
        instr    = 16'h094C;
        flags_in = 4'b0011;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort state",     16'(state),     16'h0000);
        check("abort ir",        ir,             16'h0000);
        check("abort cc",        16'(cc),        16'h0000);
        check("abort reg_write", 16'(reg_write), 16'h0000);
        check("abort mem_wen",   16'(mem_wen),   16'h0000);
        #2 rst = 1'b0;
        tick();
        check("post-reset fetch state", 16'(state), 16'h0001);
        check("post-reset fetch ir",    ir,          16'h094C);
        tick();
        check("post-reset cc", 16'(cc), 16'h0003);

        #10;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
